fetch_pipe_ctrl: RTL

- Sequential wrapper around the fetch stage of the pipelined Y86-64 core.
- Upstream, it holds the F pipeline register (predicted PC) and selects the PC that fetch reads.
- Downstream, it holds the D pipeline register that captures the decoded fetch outputs, with stall and bubble control and status generation.
- It also tracks a sticky fetch-halt condition so that no new instructions enter D after a halting or faulting fetch.

---
 rtl/fetch_pipe_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_pipe_ctrl.sv
// Fetch-stage sequential wrapper for the pipelined Y86-64 core: F register and
// PC select, D register with stall/bubble control, and sticky fetch-halt state.
module fetch_pipe_ctrl #(
  parameter logic [63:0] PC_RESET   = 64'd0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_instr_valid,
  input  logic        f_imem_error,
  input  logic        f_hlt,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  output logic [63:0] f_pc,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [2:0]  D_stat,
  output logic        fetch_halted
);

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // f_hlt mirrors icode==HALT and IMEM_BYTES is informational; both are sunk here.
  logic unused_ok;
  assign unused_ok = f_hlt ^ (IMEM_BYTES == 0);

  logic [63:0] pred_pc_q, pred_pc_d;
  logic [3:0]  d_icode_q, d_icode_d;
  logic [3:0]  d_ifun_q,  d_ifun_d;
  logic [3:0]  d_ra_q,    d_ra_d;
  logic [3:0]  d_rb_q,    d_rb_d;
  logic [63:0] d_valc_q,  d_valc_d;
  logic [63:0] d_valp_q,  d_valp_d;
  logic [2:0]  d_stat_q,  d_stat_d;
  logic        halted_q,  halted_d;

  logic [63:0] f_pred_pc;
  logic [2:0]  f_stat;
  logic [3:0]  n_icode, n_ifun, n_ra, n_rb;
  logic [63:0] n_valc;
  logic        clearing;
  logic        load_fetch;

  always_comb begin
    f_pc = pred_pc_q;
    if (M_icode == I_JXX && !M_cnd) begin
      f_pc = M_valA;
    end else if (W_icode == I_RET) begin
      f_pc = W_valM;
    end
  end

  always_comb begin
    f_pred_pc = (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;
    if (f_imem_error) begin
      f_stat = S_ADR;
    end else if (!f_instr_valid) begin
      f_stat = S_INS;
    end else if (f_icode == I_HALT) begin
      f_stat = S_HLT;
    end else begin
      f_stat = S_AOK;
    end
  end

  // Fetch leaves unused fields stale; clean them before they reach decode.
  always_comb begin
    n_icode = f_icode;
    n_ifun  = f_ifun;
    n_ra    = f_rA;
    n_rb    = f_rB;
    n_valc  = f_valC;
    if (f_icode inside {I_HALT, I_NOP, I_JXX, I_CALL, I_RET}) begin
      n_ra = R_NONE;
      n_rb = R_NONE;
    end
    if (!(f_icode inside {4'h3, 4'h4, 4'h5, I_JXX, I_CALL})) begin
      n_valc = '0;
    end
    if (f_stat == S_ADR || f_stat == S_INS) begin
      n_icode = I_NOP;
      n_ifun  = '0;
      n_ra    = R_NONE;
      n_rb    = R_NONE;
      n_valc  = '0;
    end
  end

  assign clearing   = D_bubble && !D_stall;
  assign load_fetch = !D_stall && !D_bubble && !halted_q;

  always_comb begin
    pred_pc_d = pred_pc_q;
    d_icode_d = d_icode_q;
    d_ifun_d  = d_ifun_q;
    d_ra_d    = d_ra_q;
    d_rb_d    = d_rb_q;
    d_valc_d  = d_valc_q;
    d_valp_d  = d_valp_q;
    d_stat_d  = d_stat_q;
    halted_d  = halted_q;

    if (!F_stall && !(halted_q && !clearing)) begin
      pred_pc_d = f_pred_pc;
    end

    if (load_fetch) begin
      d_icode_d = n_icode;
      d_ifun_d  = n_ifun;
      d_ra_d    = n_ra;
      d_rb_d    = n_rb;
      d_valc_d  = n_valc;
      d_valp_d  = f_valP;
      d_stat_d  = f_stat;
    end else if (!D_stall) begin
      d_icode_d = I_NOP;
      d_ifun_d  = '0;
      d_ra_d    = R_NONE;
      d_rb_d    = R_NONE;
      d_valc_d  = '0;
      d_valp_d  = '0;
      d_stat_d  = S_AOK;
    end

    // A squash outranks a halt raised on the same edge.
    if (clearing) begin
      halted_d = 1'b0;
    end else if (load_fetch && f_stat != S_AOK) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= PC_RESET;
      d_icode_q <= I_NOP;
      d_ifun_q  <= '0;
      d_ra_q    <= R_NONE;
      d_rb_q    <= R_NONE;
      d_valc_q  <= '0;
      d_valp_q  <= '0;
      d_stat_q  <= S_AOK;
      halted_q  <= 1'b0;
    end else begin
      pred_pc_q <= pred_pc_d;
      d_icode_q <= d_icode_d;
      d_ifun_q  <= d_ifun_d;
      d_ra_q    <= d_ra_d;
      d_rb_q    <= d_rb_d;
      d_valc_q  <= d_valc_d;
      d_valp_q  <= d_valp_d;
      d_stat_q  <= d_stat_d;
      halted_q  <= halted_d;
    end
  end

  assign F_predPC     = pred_pc_q;
  assign D_icode      = d_icode_q;
  assign D_ifun       = d_ifun_q;
  assign D_rA         = d_ra_q;
  assign D_rB         = d_rb_q;
  assign D_valC       = d_valc_q;
  assign D_valP       = d_valp_q;
  assign D_stat       = d_stat_q;
  assign fetch_halted = halted_q;

endmodule
